// File: rtl/div_issue_queue.sv
// div_issue_queue: operand FIFO in front of a multi-cycle unsigned divider.
// Accepts {a,b} pairs over valid/ready, issues the head entry with a
// one-cycle start pulse and holds the operands until the divider completes.
// Optional feature macro: DIVQ_TIMEOUT_EN (aborts a hung divider after
// TIMEOUT WAIT cycles, pulses div_sclr and sets the sticky timeout_err).
//
// Handshake: a pair transfers on any rising edge where in_valid && in_ready;
// in_ready depends only on queue occupancy (never on in_valid), and the
// producer must hold in_a/in_b stable while in_valid is high and in_ready low.
module div_issue_queue #(
  parameter int DEPTH   = 4,
  parameter int WIDTH   = 10,
  parameter int TIMEOUT = 31
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  input  logic                     flush,
  output logic [WIDTH-1:0]         div_a,
  output logic [WIDTH-1:0]         div_b,
  output logic                     div_start,
  output logic                     div_sclr,
  input  logic                     div_busy,
  input  logic                     div_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     idle,
  output logic                     timeout_err,
  output logic [1:0]               dbg_state
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem_a [DEPTH];
  logic [WIDTH-1:0] r_mem_b [DEPTH];
  logic [WIDTH-1:0] r_div_a;
  logic [WIDTH-1:0] r_div_b;
  logic             r_sclr;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_load;
  logic             w_abort;

  // Occupancy: pointers carry one extra wrap bit to tell full from empty.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push  = in_valid && !w_full;

  assign in_ready  = !w_full;
  assign count     = r_wr_ptr - r_rd_ptr;
  assign idle      = w_empty && (r_state == S_IDLE);
  assign div_start = (r_state == S_ISSUE);
  assign div_sclr  = r_sclr;
  assign div_a     = r_div_a;
  assign div_b     = r_div_b;
  assign dbg_state = r_state;

`ifdef DIVQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_wait_cnt;
  logic          r_timeout_err;

  // WAIT cycle counter: zeroed while issuing so it starts fresh in WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                r_wait_cnt <= '0;
    else if (flush || r_state == S_ISSUE)   r_wait_cnt <= '0;
    else if (r_state == S_WAIT)             r_wait_cnt <= r_wait_cnt + 1'b1;
  end

  // Sticky abort flag, cleared only by flush or reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_timeout_err <= 1'b0;
    else if (flush)   r_timeout_err <= 1'b0;
    else if (w_abort) r_timeout_err <= 1'b1;
  end

  assign timeout_err = r_timeout_err;
`else
  assign timeout_err = 1'b0;
`endif

  // Next state: issue when work is queued and divider free, pop on completion.
  always_comb begin
    w_next  = r_state;
    w_pop   = 1'b0;
    w_load  = 1'b0;
    w_abort = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty && !div_busy) begin
          w_next = S_ISSUE;
          w_load = 1'b1;
        end
      end
      S_ISSUE: w_next = S_WAIT;
      S_WAIT: begin
        if (div_valid) begin
          w_pop  = 1'b1;
          w_next = S_IDLE;
        end
`ifdef DIVQ_TIMEOUT_EN
        else if (r_wait_cnt == TW'(TIMEOUT - 1)) begin
          w_pop   = 1'b1;
          w_abort = 1'b1;
          w_next  = S_IDLE;
        end
`endif
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register; flush forces IDLE over any transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_state <= S_IDLE;
    else if (flush) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  // Queue pointers; flush empties the queue and wins over push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage array; a write during flush is harmless since pointers reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_a[r_wr_ptr[AW-1:0]] <= in_a;
      r_mem_b[r_wr_ptr[AW-1:0]] <= in_b;
    end
  end

  // Operand registers load from the head on IDLE->ISSUE and hold afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_a <= '0;
      r_div_b <= '0;
    end else if (!flush && w_load) begin
      r_div_a <= r_mem_a[r_rd_ptr[AW-1:0]];
      r_div_b <= r_mem_b[r_rd_ptr[AW-1:0]];
    end
  end

  // One-cycle divider clear on flush or on a timeout abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sclr <= 1'b0;
    else     r_sclr <= flush || w_abort;
  end

endmodule
